serial_transmitter: RTL and testbench
=====================================

# serial_transmitter

Parallel-to-serial transmitter: the sending end of the team's single-wire asynchronous serial link, paired with `Receiver`. It accepts a data word through a valid/ready handshake and drives it onto `serial_line` as one frame. Line idle is high, a start bit is 0, data goes LSB first, an optional parity bit follows, then the stop bit(s) at 1. Every bit is held for a fixed number of clocks.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, must be ≥ 1
- `CLKS_PER_BIT`, 10: clocks per serial bit, must be ≥ 2
- `PARITY_EN`, 0: 1 inserts a parity bit after the data
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0
- `STOP_BITS`, 1: number of stop bits, 1 or 2
- `clk` in 1: single clock; all logic is rising-edge
- `rst_n` in 1: synchronous, active-low reset
- `data_in` in `DATA_WIDTH`: word to send; sampled only on the acceptance edge
- `data_valid` in 1: a word is offered on `data_in`
- `ready` out 1: the block can accept a word this cycle
- `serial_line` out 1: serial output, registered, idle high
- `frame_done` out 1: one-cycle pulse when a frame completes

## Operation
- Reset values (the cycle after `rst_n` is sampled low): `serial_line`=1, `ready`=1, `frame_done`=0, FSM=IDLE, all counters 0.
- Acceptance happens on a rising edge where `data_valid` && `ready`. On that edge `data_in` loads the shift register and parity is computed from the loaded word.
- FSM states:
  - IDLE: `ready`=1, line=1.
  - START: line=0.
  - DATA: line=`shift[0]`; shift right after each bit.
  - PARITY: line = XOR(data) ^ `PARITY_ODD`.
  - STOP: line=1.
- FSM transitions:
  - IDLE→START on acceptance.
  - START→DATA after 1 bit period.
  - DATA→PARITY (if `PARITY_EN`) or STOP after `DATA_WIDTH` bit periods.
  - PARITY→STOP after 1 bit period.
  - STOP→IDLE after `STOP_BITS` bit periods.
- `ready` is high only in IDLE. `data_valid` outside IDLE is ignored. The block does not queue words, so the source must hold `data_valid` until it sees `ready`.
- Bit counter: `$clog2(DATA_WIDTH+1)` bits. Tick counter: `$clog2(CLKS_PER_BIT)` bits. The tick counter wraps from `CLKS_PER_BIT-1` to 0, and each wrap ends one bit period.
- `frame_done` is high in the first IDLE cycle after STOP ends, and only then.
- Reset mid-frame: the frame is aborted and there is no glitch to 0. On the next edge `serial_line`=1, `ready`=1, and `frame_done` stays 0.
- If `data_valid` is high while `rst_n` is low, no word is accepted.

## Timing
- If acceptance happens at edge N, the start bit appears on `serial_line` from edge N+1 and lasts `CLKS_PER_BIT` cycles.
- Frame length is (1 + `DATA_WIDTH` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles, counted from the first start-bit cycle.
- `ready` falls on edge N+1 and rises in the first IDLE cycle, together with `frame_done`.
- Back-to-back frames: with `data_valid` held high, the next word is accepted in that first IDLE cycle. The line is then high for exactly 1 extra clock between the stop bit and the next start bit.
- `serial_line` is driven from a flop and never from combinational logic.

## Structure
- Package `serial_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), shared with `Receiver`
  - the constants `LINE_IDLE`=1, `START_LEVEL`=0, `STOP_LEVEL`=1
- Sub-module `serial_bit_timer` holds the tick counter. Its inputs are `clk`, `rst_n` and `run`; its output is `bit_end`. While `run`=0 the count is held at 0. The same sub-module can be reused by `Receiver`.
- The top level contains the FSM, the shift register, the bit counter and the parity flop.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset: hold `rst_n`=0 for 3 cycles with `data_valid`=1. Required: `serial_line`=1, `ready`=1, `frame_done`=0, no frame starts.
- Single frame: send 0xA5 with defaults. Required: the line carries 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles, 40 cycles in total; `frame_done` pulses once; `ready` is low for exactly 40 cycles.
- Parity: `PARITY_EN`=1 with 0xA5 gives an even-parity bit of 0. With `PARITY_ODD`=1 and 0x01 the parity bit is 0. With `PARITY_ODD`=0 and 0x01 it is 1. The frame is 44 cycles.
- Back-to-back: send 0x00 then 0xFF with `data_valid` held high. Required: exactly 1 idle-high clock between the frames; the second frame's data bits are all 1.
- Reset mid-frame: assert `rst_n`=0 at cycle 15 of a 0x00 frame. Required: the line is 1 on the next edge, `ready`=1, no `frame_done`, and a new word is accepted normally afterwards.
- Loopback: connect `serial_line` to `Receiver` and send 0x3C. Required: the `Receiver` output matches 0x3C.

Source files
------------

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the single-wire asynchronous serial link. Both the
// transmitter and the receiver import this package so that the frame state
// encoding and the line levels stay identical at both ends.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_pkg;

  // Frame phases, in the order they appear on the line.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } serial_state_e;

  // Line levels for the framing bits.
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Parity over an up-to-32-bit word, with the odd/even selector folded in.
  // Unused upper bits must be zero so they do not disturb the result.
  function automatic logic calc_parity(input logic [31:0] word, input logic odd);
    calc_parity = (^word) ^ odd;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// -----------------------------------------------------------------------------
// serial_bit_timer
// Counts clocks within one serial bit period. The count wraps from
// CLKS_PER_BIT-1 to 0 and each wrap ends one bit period.
// Ports:
//   clk     in  : rising-edge clock
//   rst_n   in  : synchronous active-low reset
//   run     in  : 1 = count; 0 = hold the count at 0
//   bit_end out : high in the last clock of a bit period (only while run=1)
// -----------------------------------------------------------------------------
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_end
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;

  // Next tick count: cleared while stopped, wraps at the end of each bit.
  always_comb begin
    tick_d = {TW{1'b0}};
    if (!run) begin
      tick_d = {TW{1'b0}};
    end else if (tick_q == LAST_TICK) begin
      tick_d = {TW{1'b0}};
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  assign bit_end = run && (tick_q == LAST_TICK);

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= {TW{1'b0}};
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/serial_transmitter.sv
// -----------------------------------------------------------------------------
// serial_transmitter
// Parallel-to-serial transmitter. Accepts a word through a valid/ready
// handshake and sends it as one frame: start bit (0), data LSB first,
// optional parity bit, then STOP_BITS stop bits (1). Idle line is high.
// Ports:
//   clk         in  : rising-edge clock
//   rst_n       in  : synchronous active-low reset
//   data_in     in  : word to send, sampled on the acceptance edge only
//   data_valid  in  : a word is offered on data_in
//   ready       out : block can accept a word this cycle (high only in IDLE)
//   serial_line out : registered serial output, idle high
//   frame_done  out : one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module serial_transmitter
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  ready,
  output logic                  serial_line,
  output logic                  frame_done
);

  localparam int BW = (DATA_WIDTH > 0) ? $clog2(DATA_WIDTH + 1) : 1;
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic PAR_ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  serial_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  par_q, par_d;
  logic                  line_q, line_d;
  logic                  ready_q, ready_d;
  logic                  frame_done_q, frame_done_d;
  logic                  bit_end_s;

  // The timer only runs while a frame is on the line, so every phase
  // starts with a fresh, full-length bit period.
  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_q != IDLE),
    .bit_end(bit_end_s)
  );

  // Next-state, shift register, bit counter and parity.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    case (state_q)
      IDLE: begin
        if (data_valid && ready_q) begin
          state_d   = START;
          shift_d   = data_in;
          par_d     = calc_parity(32'(data_in), PAR_ODD_BIT);
          bit_cnt_d = {BW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = {BW{1'b0}};
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        // The bit counter is reused to count stop bits.
        if (bit_end_s) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = {BW{1'b0}};
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = {BW{1'b0}};
      end
    endcase
  end

  // Outputs are decoded from the next state so that the registered line
  // changes on the same edge as the state, with no extra cycle of lag.
  always_comb begin
    line_d = LINE_IDLE;
    case (state_d)
      IDLE:    line_d = LINE_IDLE;
      START:   line_d = START_LEVEL;
      DATA:    line_d = shift_d[0];
      PARITY:  line_d = par_d;
      STOP:    line_d = STOP_LEVEL;
      default: line_d = LINE_IDLE;
    endcase
    ready_d      = (state_d == IDLE);
    frame_done_d = (state_q == STOP) && (state_d == IDLE);
  end

  // State and output registers; reset drives the line straight to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= {DATA_WIDTH{1'b0}};
      bit_cnt_q    <= {BW{1'b0}};
      par_q        <= 1'b0;
      line_q       <= LINE_IDLE;
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      line_q       <= line_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign serial_line = line_q;
  assign ready       = ready_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// -----------------------------------------------------------------------------
// tb_serial_transmitter
// Three transmitter instances at CLKS_PER_BIT=4: no parity, even parity and
// odd parity. Expected line sequences are hand-written, first transmitted bit
// in the MSB of an 11-bit field. Inputs change on the falling edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_transmitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic [2:0] valid;
  logic [2:0] line_w;
  logic [2:0] rdy_w;
  logic [2:0] done_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_transmitter #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_def (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(valid[0]),
    .ready(rdy_w[0]), .serial_line(line_w[0]), .frame_done(done_w[0])
  );

  serial_transmitter #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_even (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(valid[1]),
    .ready(rdy_w[1]), .serial_line(line_w[1]), .frame_done(done_w[1])
  );

  serial_transmitter #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) u_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(valid[2]),
    .ready(rdy_w[2]), .serial_line(line_w[2]), .frame_done(done_w[2])
  );

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [10:0] exp;    // time-ordered: first bit in [10]
    int          nbits;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Offer a word at a falling edge; return at the falling edge inside the
  // first start-bit cycle.
  task automatic start_word(input int dut, input logic [7:0] d, input bit hold);
    chk($sformatf("ready_before d%0d", dut), 32'(rdy_w[dut]), 32'd1);
    data_in    = d;
    valid[dut] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      valid[dut] = 1'b0;
    end else begin
      valid[dut] = 1'b1;
    end
  endtask

  // Check a full frame cycle by cycle, decode it by mid-bit sampling, and
  // finish at the falling edge of the first IDLE cycle.
  task automatic check_frame(input int dut, input logic [10:0] exp, input int nbits,
                             input logic [7:0] data);
    logic [10:0] smp;
    logic [7:0]  rx;
    int          ready_low;
    int          done_cnt;
    smp       = 11'd0;
    ready_low = 0;
    done_cnt  = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int t = 0; t < 4; t++) begin
        chk($sformatf("line d%0d bit%0d t%0d", dut, b, t), 32'(line_w[dut]), 32'(exp[10-b]));
        if (rdy_w[dut] == 1'b0) ready_low++;
        if (done_w[dut] == 1'b1) done_cnt++;
        if (t == 2) smp[b] = line_w[dut];
        @(negedge clk);
      end
    end
    for (int i = 0; i < 8; i++) rx[i] = smp[1+i];
    chk($sformatf("ready_low_cycles d%0d", dut), 32'(ready_low), 32'(nbits * 4));
    chk($sformatf("done_in_frame d%0d", dut), 32'(done_cnt), 32'd0);
    chk($sformatf("loopback d%0d", dut), 32'(rx), 32'(data));
    chk($sformatf("idle_line d%0d", dut), 32'(line_w[dut]), 32'd1);
    chk($sformatf("idle_ready d%0d", dut), 32'(rdy_w[dut]), 32'd1);
    chk($sformatf("frame_done d%0d", dut), 32'(done_w[dut]), 32'd1);
  endtask

  initial begin
    vecs[0] = '{dut: 0, data: 8'hA5, exp: 11'b01010010110, nbits: 10};
    vecs[1] = '{dut: 1, data: 8'hA5, exp: 11'b01010010101, nbits: 11};
    vecs[2] = '{dut: 2, data: 8'h01, exp: 11'b01000000001, nbits: 11};
    vecs[3] = '{dut: 1, data: 8'h01, exp: 11'b01000000011, nbits: 11};
    vecs[4] = '{dut: 0, data: 8'h3C, exp: 11'b00011110010, nbits: 10};
    vecs[5] = '{dut: 0, data: 8'h00, exp: 11'b00000000010, nbits: 10};
    vecs[6] = '{dut: 2, data: 8'hFF, exp: 11'b01111111111, nbits: 11};

    // Reset with data_valid high: nothing may be accepted.
    rst_n   = 1'b0;
    valid   = 3'b111;
    data_in = 8'h55;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("rst_line d%0d", d), 32'(line_w[d]), 32'd1);
        chk($sformatf("rst_ready d%0d", d), 32'(rdy_w[d]), 32'd1);
        chk($sformatf("rst_done d%0d", d), 32'(done_w[d]), 32'd0);
      end
    end
    valid = 3'b000;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("post_rst_line d%0d", d), 32'(line_w[d]), 32'd1);
        chk($sformatf("post_rst_ready d%0d", d), 32'(rdy_w[d]), 32'd1);
      end
    end

    // Table of single frames.
    for (int i = 0; i < 7; i++) begin
      start_word(vecs[i].dut, vecs[i].data, 1'b0);
      check_frame(vecs[i].dut, vecs[i].exp, vecs[i].nbits, vecs[i].data);
      @(negedge clk);
      chk($sformatf("done_pulse_once v%0d", i), 32'(done_w[vecs[i].dut]), 32'd0);
    end

    // Back-to-back: 0x00 then 0xFF with data_valid held; data_in changes
    // mid-frame to show it is sampled only at acceptance.
    start_word(0, 8'h00, 1'b1);
    data_in = 8'hFF;
    check_frame(0, 11'b00000000010, 10, 8'h00);
    @(negedge clk);
    valid[0] = 1'b0;
    check_frame(0, 11'b01111111110, 10, 8'hFF);
    @(negedge clk);
    chk("b2b_done_once", 32'(done_w[0]), 32'd0);

    // Reset in cycle 15 of a 0x00 frame.
    start_word(0, 8'h00, 1'b0);
    repeat (15) @(negedge clk);
    chk("midframe_line_before", 32'(line_w[0]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_line", 32'(line_w[0]), 32'd1);
    chk("midrst_ready", 32'(rdy_w[0]), 32'd1);
    chk("midrst_done", 32'(done_w[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_line", 32'(line_w[0]), 32'd1);
    chk("after_rst_done", 32'(done_w[0]), 32'd0);
    start_word(0, 8'hA5, 1'b0);
    check_frame(0, 11'b01010010110, 10, 8'hA5);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
